// File: rtl/ws2811_frame_driver_if.sv
// Byte stream handshake into the WS2811 frame driver.
// The master drives data/valid and the driver returns ready.
interface ws2811_frame_driver_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ws2811_frame_driver.sv
// WS2811/WS2812 strip driver: byte FIFO, frame sequencer, NRZ bit timing and latch gap.
//   state | meaning
//   IDLE  | line low, waiting for start
//   SEND  | shifting frame bytes out MSB first, one BIT_CYCLES period per bit
//   LATCH | line held low for RESET_CYCLES, frame_done on the last cycle
module ws2811_frame_driver #(
    parameter int N_LEDS       = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 6000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ws2811_frame_driver_if.slave          in_if,
    input  logic                          start,
    output logic                          dout,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;
    localparam int FRAME_BYTES = 3 * N_LEDS;
    localparam int CCW         = $clog2(BIT_CYCLES);
    localparam int BCW         = $clog2(FRAME_BYTES > 1 ? FRAME_BYTES : 2);
    localparam int LCW         = $clog2(RESET_CYCLES > 1 ? RESET_CYCLES : 2);

    localparam logic [CCW-1:0] CC_LAST   = CCW'(BIT_CYCLES - 1);
    localparam logic [CCW-1:0] T0H       = CCW'(T0H_CYCLES);
    localparam logic [CCW-1:0] T1H       = CCW'(T1H_CYCLES);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(FRAME_BYTES - 1);
    localparam logic [LCW-1:0] LAT_LOAD  = LCW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  FULL_LVL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t         state, state_nxt;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic           in_ready_q;
    logic           push, pop, fifo_empty;
    logic [7:0]     head;

    logic [7:0]     sh, sh_nxt;
    logic [2:0]     bit_cnt, bit_nxt;
    logic [BCW-1:0] byte_cnt, byte_nxt;
    logic [CCW-1:0] cc, cc_nxt, th_nxt;
    logic [LCW-1:0] lat, lat_nxt;
    logic           complete, complete_nxt;
    logic           dout_d, underrun_d;

    assign push            = in_if.in_valid && in_ready_q;
    assign in_if.in_ready  = in_ready_q;
    assign fill_level      = count;
    assign fifo_empty      = (count == '0);
    assign head            = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_if.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
            sh         <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            cc         <= '0;
            lat        <= '0;
            complete   <= 1'b0;
            dout       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            in_ready_q <= (count_nxt != FULL_LVL);
            sh         <= sh_nxt;
            bit_cnt    <= bit_nxt;
            byte_cnt   <= byte_nxt;
            cc         <= cc_nxt;
            lat        <= lat_nxt;
            complete   <= complete_nxt;
            dout       <= dout_d;
            underrun   <= underrun_d;
        end
    end

    // The next byte is fetched on the last cycle of bit 0 so bytes abut with no gap.
    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        bit_nxt      = bit_cnt;
        byte_nxt     = byte_cnt;
        cc_nxt       = cc;
        lat_nxt      = lat;
        complete_nxt = complete;
        pop          = 1'b0;
        underrun_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        sh_nxt       = head;
                        bit_nxt      = '0;
                        byte_nxt     = '0;
                        cc_nxt       = '0;
                        complete_nxt = 1'b0;
                        state_nxt    = SEND;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (cc == CC_LAST) begin
                    cc_nxt = '0;
                    if (bit_cnt != 3'd7) begin
                        sh_nxt  = {sh[6:0], 1'b0};
                        bit_nxt = bit_cnt + 3'd1;
                    end else if (byte_cnt == BYTE_LAST) begin
                        state_nxt    = LATCH;
                        lat_nxt      = LAT_LOAD;
                        complete_nxt = 1'b1;
                    end else if (fifo_empty) begin
                        state_nxt  = LATCH;
                        lat_nxt    = LAT_LOAD;
                        underrun_d = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        sh_nxt   = head;
                        bit_nxt  = '0;
                        byte_nxt = byte_cnt + BCW'(1);
                    end
                end else begin
                    cc_nxt = cc + CCW'(1);
                end
            end
            LATCH: begin
                if (lat == '0) state_nxt = IDLE;
                else           lat_nxt   = lat - LCW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dout is registered from the next-cycle bit position to keep the line glitch-free.
    always_comb begin
        th_nxt     = sh_nxt[7] ? T1H : T0H;
        dout_d     = (state_nxt == SEND) && (cc_nxt < th_nxt);
        busy       = (state != IDLE);
        frame_done = (state == LATCH) && (lat == '0) && complete;
    end

endmodule

// File: tb/tb_ws2811_frame_driver.sv
// Bench for ws2811_frame_driver: queue-based line model compared every cycle,
// plus directed scenarios with hand-computed timings.
module tb_ws2811_frame_driver;
    localparam int N_LEDS      = 2;
    localparam int DEPTH       = 4;
    localparam int BC          = 125;
    localparam int T0H         = 40;
    localparam int T1H         = 80;
    localparam int RST         = 600;
    localparam int FRAME_BYTES = 3 * N_LEDS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dout, busy, frame_done, underrun;
    logic [2:0] fill_level;

    ws2811_frame_driver_if bus();

    ws2811_frame_driver #(
        .N_LEDS(N_LEDS), .FIFO_DEPTH(DEPTH), .BIT_CYCLES(BC),
        .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bus), .start(start),
        .dout(dout), .busy(busy), .frame_done(frame_done),
        .underrun(underrun), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit stream_on = 1'b0;
    logic [7:0] pend[$];

    // model: FIFO contents, bytes of the current frame, and elapsed time in the phase
    logic [7:0] m_q[$];
    logic [7:0] m_frame[$];
    int m_mode = 0;
    int m_t = 0;
    int m_lt = 0;
    bit m_ok = 1'b0;
    bit m_und = 1'b0;
    bit m_push;
    logic e_bit, e_dout;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_und = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_frame.delete();
            m_mode = 0;
            m_t = 0;
            m_lt = 0;
            m_ok = 1'b0;
        end else begin
            m_push = bus.in_valid && (m_q.size() < DEPTH);
            case (m_mode)
                0: if (start) begin
                    if (m_q.size() > 0) begin
                        m_frame.delete();
                        m_frame.push_back(m_q.pop_front());
                        m_mode = 1;
                        m_t = 0;
                        m_ok = 1'b0;
                    end else m_und = 1'b1;
                end
                1: begin
                    m_t++;
                    if (m_t == m_frame.size() * 8 * BC) begin
                        if (m_frame.size() == FRAME_BYTES) begin
                            m_mode = 2; m_lt = 0; m_ok = 1'b1;
                        end else if (m_q.size() == 0) begin
                            m_mode = 2; m_lt = 0; m_ok = 1'b0; m_und = 1'b1;
                        end else m_frame.push_back(m_q.pop_front());
                    end
                end
                default: begin
                    m_lt++;
                    if (m_lt == RST) m_mode = 0;
                end
            endcase
            if (m_push) m_q.push_back(bus.in_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_dout = 1'b0;
            if (m_mode == 1) begin
                e_bit  = m_frame[m_t / (8 * BC)][7 - ((m_t / BC) % 8)];
                e_dout = ((m_t % BC) < (e_bit ? T1H : T0H));
            end
            check("dout", int'(dout), int'(e_dout));
            check("busy", int'(busy), int'(m_mode != 0));
            check("frame_done", int'(frame_done), int'(m_mode == 2 && m_lt == RST - 1 && m_ok));
            check("underrun", int'(underrun), int'(m_und));
            check("fill_level", int'(fill_level), m_q.size());
            check("in_ready", int'(bus.in_ready), int'(m_q.size() < DEPTH));
        end
    end

    task automatic tick();
        bit acc;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) begin
            if (stream_on) bus.in_data = bus.in_data + 8'd1;
            else begin
                if (pend.size() > 0) void'(pend.pop_front());
                if (pend.size() > 0) bus.in_data = pend[0];
                else bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic prefill();
        int n = 0;
        bus.in_data  = pend[0];
        bus.in_valid = 1'b1;
        while (fill_level != 3'd4 && n < 20) begin tick(); n++; end
        check("prefill", int'(fill_level), 4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int exp_hi[24] = '{80, 80, 80, 80, 80, 80, 80, 80,
                       40, 40, 40, 40, 40, 40, 40, 40,
                       80, 40, 80, 40, 40, 80, 40, 80};
    int hi[48];
    int n, fd_cnt, und_cnt, und_idx;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fill", int'(fill_level), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        tick();

        // FIFO full: ten cycles of valid while idle
        stream_on = 1'b1;
        bus.in_data  = 8'h10;
        bus.in_valid = 1'b1;
        repeat (10) tick();
        check("full_fill", int'(fill_level), 4);
        check("full_in_ready", int'(bus.in_ready), 0);

        // three streamed frames, pointers wrap, stray starts in SEND and LATCH
        fd_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            start = 1'b1;
            tick();
            check("start_busy", int'(busy), 1);
            check("start_dout", int'(dout), 1);
            n = 0;
            while (busy && n < 8000) begin
                if (frame_done) fd_cnt++;
                if (n == 3000 || n == 6100) start = 1'b1;
                tick();
                n++;
            end
            check("frame_idle", int'(busy), 0);
            check("frame_len", n, 48 * BC + RST);
            tick();
        end
        check("frame_done_count", fd_cnt, 3);
        stream_on    = 1'b0;
        bus.in_valid = 1'b0;

        // reset 200 cycles into a frame
        start = 1'b1;
        tick();
        repeat (199) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_dout", int'(dout), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_fill", int'(fill_level), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        tick();

        // first pixel FF 00 A5: per-bit high times
        pend = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h81, 8'h7E};
        prefill();
        start = 1'b1;
        tick();
        for (int i = 0; i < 48; i++) hi[i] = 0;
        for (int s = 0; s < 48 * BC; s++) begin
            if (dout) hi[s / BC]++;
            tick();
        end
        for (int i = 0; i < 24; i++) check("bit_high_time", hi[i], exp_hi[i]);
        n = 0;
        while (!frame_done && n < 700) begin tick(); n++; end
        check("latch_to_done", n, RST - 1);
        tick();
        check("after_done_busy", int'(busy), 0);

        // underrun after byte index 3 with a start issued during LATCH
        pend = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
        prefill();
        start = 1'b1;
        tick();
        n = 0; und_cnt = 0; und_idx = -1; fd_cnt = 0;
        while (busy && n < 8000) begin
            if (underrun) begin und_cnt++; if (und_idx < 0) und_idx = n; end
            if (frame_done) fd_cnt++;
            if (n == 4100) start = 1'b1;
            tick();
            n++;
        end
        check("und_count", und_cnt, 1);
        check("und_index", und_idx, 4 * 8 * BC);
        check("und_no_done", fd_cnt, 0);
        check("und_idle_at", n, 4 * 8 * BC + RST);

        // start with an empty FIFO
        start = 1'b1;
        tick();
        check("empty_underrun", int'(underrun), 1);
        check("empty_busy", int'(busy), 0);
        tick();
        check("empty_underrun_clear", int'(underrun), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ws2811_frame_driver.md
# ws2811_frame_driver

Parametrised WS2811/WS2812 strip driver. It accepts a GRB byte stream into an internal FIFO, frames it into exactly `N_LEDS` × 24 bits, and drives the single-wire NRZ line with cycle-accurate high and low times. It then generates the latch (reset) gap. It replaces the separate FIFO, controller and PWM trio with one block that adds a ready/valid input, frame counting, zero-gap byte prefetch and underrun detection.

## Interface
Parameters:
- `N_LEDS`, 8: pixels per frame; frame length is 3·`N_LEDS` bytes.
- `FIFO_DEPTH`, 64: byte FIFO depth; must be a power of 2 and ≥ 2.
- `BIT_CYCLES`, 125: clocks per bit; 1.25 µs at 100 MHz.
- `T0H_CYCLES`, 40: high time of a 0 bit.
- `T1H_CYCLES`, 80: high time of a 1 bit. Must satisfy 0 < `T0H_CYCLES` < `T1H_CYCLES` < `BIT_CYCLES`.
- `RESET_CYCLES`, 6000: latch low time, 60 µs.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `in_data` in 8: byte to enqueue. Order is G, R, B per pixel; each byte is sent MSB first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO not full. A push occurs when `in_valid && in_ready`.
- `start` in 1: one-cycle request to transmit a frame. It is honoured only in IDLE.
- `dout` out 1: WS2811 data line.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at the end of LATCH after a complete frame.
- `underrun` out 1: one-cycle pulse when a byte is needed and the FIFO is empty.
- `fill_level` out clog2(`FIFO_DEPTH`)+1: bytes currently held in the FIFO.

## Operation
- FIFO
  - First-word-fall-through, circular pointers with wrap at `FIFO_DEPTH`.
  - Push and pop in the same cycle leave `fill_level` unchanged.
  - When full, `in_ready` is 0 and pushes are ignored.
  - A pop is never issued when the FIFO is empty.
- State machine: IDLE → SEND → LATCH → IDLE.
- IDLE
  - `dout` = 0.
  - On `start` with `fill_level` ≥ 1: pop the head byte into the shift register, clear the bit counter (0..7) and byte counter (0..3·`N_LEDS`−1), and enter SEND.
  - On `start` with an empty FIFO: pulse `underrun` and stay in IDLE.
- SEND
  - Cycle counter `cc` runs 0..`BIT_CYCLES`−1.
  - `dout` = 1 while `cc` < THx, where THx is `T1H_CYCLES` if the current bit is 1, else `T0H_CYCLES`. Otherwise `dout` = 0.
  - At `cc` = `BIT_CYCLES`−1, shift to the next bit.
  - After bit 0 of a byte that is not the last byte of the frame:
    - The next byte is popped at that same cycle, so there is no inter-byte gap.
    - If the FIFO is empty at that cycle: pulse `underrun`, abort the frame, and enter LATCH. `frame_done` will not pulse for this frame.
  - After bit 0 of the last byte (index 3·`N_LEDS`−1): enter LATCH.
- LATCH
  - `dout` = 0 for exactly `RESET_CYCLES` clocks, then return to IDLE.
  - Pulse `frame_done` on the final LATCH cycle, but only if the frame completed.
- Bytes beyond one frame stay in the FIFO for the next `start`.
- `start` while `busy` is ignored; it is not queued.
- Counter widths are sized by clog2 of each limit. No counter may wrap within its range.
- Reset
  - All outputs are 0 except `in_ready`, which is 1.
  - FIFO emptied, `fill_level` = 0, state IDLE.
  - Reset asserted mid-frame forces `dout` = 0 at the next edge and discards the partial frame.

## Timing
- `start` sampled at edge k (IDLE, FIFO non-empty):
  - `busy` = 1 and `dout` = 1 from edge k+1.
  - `fill_level` decrements at edge k+1, adjusted for a simultaneous push.
- Each bit occupies exactly `BIT_CYCLES` clocks. `dout` rises on the first clock of every bit.
- Frame duration is 24·`N_LEDS`·`BIT_CYCLES` clocks of SEND, followed by `RESET_CYCLES` clocks of LATCH.
- `frame_done` is high in the same cycle as the last LATCH clock. `busy` = 0 on the following cycle.
- `in_ready` is a registered not-full flag. A push in the cycle the FIFO becomes full is accepted; the next cycle shows `in_ready` = 0.
- `underrun` is registered and occurs in the cycle after the failed fetch edge.
  - On an abort, `dout` is already 0 because the bit period has ended, and LATCH starts the next cycle.

## Test plan
- Reset mid-SEND: assert `rst_n` = 0 at cycle 200 of a frame.
  - Next cycle: `dout` = 0, `busy` = 0, `fill_level` = 0, `in_ready` = 1.
- Single pixel, `N_LEDS` = 1: push 0xFF, 0x00, 0xA5, then `start`.
  - Bits 1–8 are high for 80 cycles each, bits 9–16 for 40 cycles, and bits 17–24 follow the pattern 80,40,80,40,40,80,40,80, each period 125 cycles.
  - Then 6000 low cycles, then a `frame_done` pulse, with no gaps anywhere.
- Underrun: `N_LEDS` = 2, push only 4 bytes, `start`.
  - `underrun` pulses once, after the fetch cycle at the end of byte 3 (index 3).
  - `dout` stays low for 6000 cycles, then IDLE, with no `frame_done`.
- FIFO full and wrap: `FIFO_DEPTH` = 4, hold `in_valid` for 10 cycles while idle.
  - Exactly 4 bytes accepted, `in_ready` = 0, `fill_level` = 4.
  - Repeat 3 frames with `N_LEDS` = 1 so the pointers wrap; output bytes match input order.
- Concurrent push/pop: stream bytes continuously during SEND.
  - `fill_level` stays consistent, and the second frame starts from byte 3·`N_LEDS`.
- `start` during LATCH, or with an empty FIFO in IDLE:
  - During LATCH: no effect.
  - Empty FIFO in IDLE: `underrun` pulse, `busy` stays 0.
